// File: rtl/pool_window_feeder_pkg.sv
// Shared sizes, pad value and column-bus layout helper for the pool window feeder.
// Every file of the feeder imports this package.
package pool_window_feeder_pkg;

    localparam int unsigned FEATURE_WIDTH = 16;
    localparam int unsigned MAXPOOL_SIZE  = 5;
    localparam int unsigned PE_ARRAY_SIZE = 8;

    localparam logic [FEATURE_WIDTH-1:0] PAD_VALUE = 16'h8000;

    localparam int unsigned ROW_WIDTH = FEATURE_WIDTH * PE_ARRAY_SIZE;
    localparam int unsigned COL_WIDTH = ROW_WIDTH * MAXPOOL_SIZE;
    localparam int unsigned CNT_WIDTH = $clog2(MAXPOOL_SIZE);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t LAST_IDX = cnt_t'(MAXPOOL_SIZE - 1);

    // Bit offset of (lane, row) inside a column word: rows of one lane are contiguous.
    function automatic int unsigned col_offset(input int unsigned lane, input int unsigned row);
        return (lane * MAXPOOL_SIZE + row) * FEATURE_WIDTH;
    endfunction

endpackage

// File: rtl/pool_column_gather.sv
// Collects row beats into one column word, pads missing rows and detects column close.
// A closed column that cannot be handed over immediately is held here as pending.
module pool_column_gather
    import pool_window_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_valid,
    output logic                 beat_ready,
    input  logic [ROW_WIDTH-1:0] beat_data,
    input  logic                 beat_last,
    input  logic                 beat_frame_end,
    input  logic                 col_take,
    output logic                 col_avail,
    output logic [COL_WIDTH-1:0] col_data,
    output logic                 col_frame_end
);

    logic [COL_WIDTH-1:0] hold_q;
    logic [COL_WIDTH-1:0] col_next;
    cnt_t                 row_cnt_q;
    logic                 pending_q;
    logic                 pend_fe_q;
    logic                 accept;
    logic                 close;

    assign beat_ready = !pending_q;
    assign accept     = beat_valid && beat_ready;
    assign close      = accept && (row_cnt_q == LAST_IDX || beat_last || beat_frame_end);

    // Rows above the current slot read as pad; they are overwritten by later beats
    // unless the column closes first, so the same word serves both cases.
    always_comb begin
        col_next = hold_q;
        for (int l = 0; l < int'(PE_ARRAY_SIZE); l++) begin
            for (int r = 0; r < int'(MAXPOOL_SIZE); r++) begin
                if (cnt_t'(r) == row_cnt_q) begin
                    col_next[col_offset(l, r) +: FEATURE_WIDTH] =
                        beat_data[l*FEATURE_WIDTH +: FEATURE_WIDTH];
                end else if (cnt_t'(r) > row_cnt_q) begin
                    col_next[col_offset(l, r) +: FEATURE_WIDTH] = PAD_VALUE;
                end
            end
        end
    end

    assign col_avail     = pending_q || close;
    assign col_data      = pending_q ? hold_q : col_next;
    assign col_frame_end = pending_q ? pend_fe_q : beat_frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            row_cnt_q <= '0;
            pending_q <= 1'b0;
            pend_fe_q <= 1'b0;
        end else if (accept) begin
            hold_q    <= col_next;
            row_cnt_q <= close ? '0 : row_cnt_q + cnt_t'(1);
            if (close && !col_take) begin
                pending_q <= 1'b1;
                pend_fe_q <= beat_frame_end;
            end
        end else if (pending_q && col_take) begin
            pending_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pool_window_feeder.sv
// Column-bus feeder for the max-pool array: output register, valid/ready handshake
// and the window column counter that drives pulse.
module pool_window_feeder
    import pool_window_feeder_pkg::*;
(
    input  logic                 DSP_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROW_WIDTH-1:0] in_data,
    input  logic                 in_last,
    input  logic                 in_frame_end,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COL_WIDTH-1:0] out_feature,
    output logic                 pulse,
    output logic                 out_frame_end
);

    logic                 take;
    logic                 handshake;
    logic                 col_avail;
    logic [COL_WIDTH-1:0] col_data;
    logic                 col_frame_end;
    cnt_t                 col_cnt_q;
    cnt_t                 col_cnt_d;

    assign handshake = out_valid && out_ready;
    assign take      = !out_valid || out_ready;

    pool_column_gather u_gather (
        .clk           (DSP_clk),
        .rst           (rst),
        .beat_valid    (in_valid),
        .beat_ready    (in_ready),
        .beat_data     (in_data),
        .beat_last     (in_last),
        .beat_frame_end(in_frame_end),
        .col_take      (take),
        .col_avail     (col_avail),
        .col_data      (col_data),
        .col_frame_end (col_frame_end)
    );

    // col_d is the window position of whatever column sits in the register next cycle.
    always_comb begin
        col_cnt_d = col_cnt_q;
        if (handshake) begin
            if (out_frame_end || col_cnt_q == LAST_IDX) begin
                col_cnt_d = '0;
            end else begin
                col_cnt_d = col_cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge DSP_clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_feature   <= '0;
            pulse         <= 1'b0;
            out_frame_end <= 1'b0;
            col_cnt_q     <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            if (take) begin
                if (col_avail) begin
                    out_valid     <= 1'b1;
                    out_feature   <= col_data;
                    pulse         <= (col_cnt_d == '0);
                    out_frame_end <= col_frame_end;
                end else begin
                    out_valid     <= 1'b0;
                    pulse         <= 1'b0;
                    out_frame_end <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder: vector table plus handshake sequences,
// with a column scoreboard fed by a bench-side gather model.
module tb_pool_window_feeder;
    import pool_window_feeder_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROW_WIDTH-1:0] in_data;
    logic                 in_last;
    logic                 in_frame_end;
    logic                 out_valid;
    logic                 out_ready;
    logic [COL_WIDTH-1:0] out_feature;
    logic                 pulse;
    logic                 out_frame_end;

    pool_window_feeder dut (
        .DSP_clk      (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_frame_end (in_frame_end),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_feature  (out_feature),
        .pulse        (pulse),
        .out_frame_end(out_frame_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [COL_WIDTH-1:0] w;
        logic                 p;
        logic                 fe;
    } exp_t;

    typedef struct {
        int          nrows;
        logic [79:0] rows;
        logic        last;
        logic        fe;
        logic [79:0] exp_lane0;
    } vec_t;

    exp_t                 sb[$];
    logic [ROW_WIDTH-1:0] m_rows[5];
    int                   m_cnt;
    int                   m_col;
    int                   n_checks = 0;
    int                   n_pass = 0;
    int                   pulse_seen;
    int                   fe_seen;
    vec_t                 vecs[6];

    task automatic chk(input string name, input logic [COL_WIDTH-1:0] act,
                       input logic [COL_WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [ROW_WIDTH-1:0] mk_row(input logic [15:0] v);
        logic [ROW_WIDTH-1:0] r;
        for (int l = 0; l < 8; l++) r[l*16 +: 16] = v + 16'(l * 16'h0111);
        return r;
    endfunction

    task automatic model_accept(input logic [ROW_WIDTH-1:0] d, input logic last,
                                input logic fe);
        exp_t e;
        m_rows[m_cnt] = d;
        if (m_cnt == 4 || last || fe) begin
            for (int l = 0; l < 8; l++)
                for (int r = 0; r < 5; r++)
                    e.w[(l*5+r)*16 +: 16] = (r <= m_cnt) ? m_rows[r][l*16 +: 16] : 16'h8000;
            e.p  = (m_col == 0);
            e.fe = fe;
            sb.push_back(e);
            m_col = fe ? 0 : (m_col == 4 ? 0 : m_col + 1);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic drive_beat(input logic [ROW_WIDTH-1:0] d, input logic last,
                              input logic fe, output int waited);
        logic rdy;
        waited       = 0;
        in_valid     = 1'b1;
        in_data      = d;
        in_last      = last;
        in_frame_end = fe;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                $display("FAIL beat_accept_timeout: got no accept expected accept within 50");
                break;
            end
        end
        if (rdy) model_accept(d, last, fe);
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_frame_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_col = 0;
    endtask

    // Scoreboard: compare every column at the moment its handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (pulse) pulse_seen++;
            if (out_frame_end) fe_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_column: got %0h expected none", out_feature);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("column_data", out_feature, e.w);
                chk("column_pulse", COL_WIDTH'(pulse), COL_WIDTH'(e.p));
                chk("column_frame_end", COL_WIDTH'(out_frame_end), COL_WIDTH'(e.fe));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        logic [COL_WIDTH-1:0] held;

        vecs[0] = '{5, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0,
                    {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}};
        vecs[1] = '{2, {16'd0, 16'd0, 16'd0, 16'd2, 16'd1}, 1'b1, 1'b0,
                    {16'h8000, 16'h8000, 16'h8000, 16'd2, 16'd1}};
        vecs[2] = '{1, {16'd0, 16'd0, 16'd0, 16'd0, 16'h7fff}, 1'b1, 1'b0,
                    {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7fff}};
        vecs[3] = '{3, {16'd0, 16'd0, 16'h000c, 16'h000b, 16'h000a}, 1'b0, 1'b1,
                    {16'h8000, 16'h8000, 16'h000c, 16'h000b, 16'h000a}};
        vecs[4] = '{5, {16'hffff, 16'h8001, 16'h0000, 16'h7fff, 16'h1234}, 1'b0, 1'b1,
                    {16'hffff, 16'h8001, 16'h0000, 16'h7fff, 16'h1234}};
        vecs[5] = '{4, {16'd0, 16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1'b1, 1'b1,
                    {16'h8000, 16'h0044, 16'h0033, 16'h0022, 16'h0011}};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        in_frame_end = 1'b0;
        out_ready    = 1'b1;
        pulse_seen   = 0;
        fe_seen      = 0;
        m_cnt        = 0;
        m_col        = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", COL_WIDTH'(out_valid), '0);
        chk("reset_pulse", COL_WIDTH'(pulse), '0);
        chk("reset_frame_end", COL_WIDTH'(out_frame_end), '0);
        chk("reset_feature", out_feature, '0);
        chk("reset_in_ready", COL_WIDTH'(in_ready), COL_WIDTH'(1));
        rst = 1'b0;

        // Single-column vectors, each from a fresh reset so pulse must be 1.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int r = 0; r < vecs[v].nrows; r++) begin
                drive_beat(mk_row(vecs[v].rows[r*16 +: 16]),
                           vecs[v].last && (r == vecs[v].nrows - 1),
                           vecs[v].fe && (r == vecs[v].nrows - 1), w);
            end
            chk($sformatf("vec%0d_out_valid", v), COL_WIDTH'(out_valid), COL_WIDTH'(1));
            chk($sformatf("vec%0d_lane0", v), COL_WIDTH'(out_feature[79:0]),
                COL_WIDTH'(vecs[v].exp_lane0));
            chk($sformatf("vec%0d_pulse", v), COL_WIDTH'(pulse), COL_WIDTH'(1));
            chk($sformatf("vec%0d_frame_end", v), COL_WIDTH'(out_frame_end),
                COL_WIDTH'(vecs[v].fe));
            chk($sformatf("vec%0d_in_ready", v), COL_WIDTH'(in_ready), COL_WIDTH'(1));
            @(posedge clk);
            #1;
        end

        // 25 back-to-back beats: out_valid only in the cycle after each 5th beat.
        do_reset();
        for (int j = 1; j <= 25; j++) begin
            drive_beat(mk_row(16'(j * 7)), 1'b0, 1'b0, w);
            chk($sformatf("b2b_wait_beat%0d", j), COL_WIDTH'(w), '0);
            chk($sformatf("b2b_out_valid_beat%0d", j), COL_WIDTH'(out_valid),
                COL_WIDTH'(j % 5 == 0));
        end
        @(posedge clk);
        #1;

        // Backpressure: second column parks in the gather, in_ready drops.
        do_reset();
        out_ready = 1'b0;
        wsum      = 0;
        held      = '0;
        for (int j = 1; j <= 10; j++) begin
            drive_beat(mk_row(16'(16'h0200 + j)), 1'b0, 1'b0, w);
            wsum += w;
            if (j == 5) held = out_feature;
        end
        chk("bp_no_stall_before_close", COL_WIDTH'(wsum), '0);
        chk("bp_in_ready_low", COL_WIDTH'(in_ready), '0);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_word_stable", out_feature, held);
        chk("bp_valid_held", COL_WIDTH'(out_valid), COL_WIDTH'(1));
        chk("bp_pulse_held", COL_WIDTH'(pulse), COL_WIDTH'(1));
        chk("bp_in_ready_still_low", COL_WIDTH'(in_ready), '0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_back", COL_WIDTH'(in_ready), COL_WIDTH'(1));
        chk("bp_drained", COL_WIDTH'(sb.size()), '0);

        // Frame of 7 columns then one more: pulses on columns 0, 5 and the next frame.
        do_reset();
        pulse_seen = 0;
        fe_seen    = 0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 5; r++)
                drive_beat(mk_row(16'(c * 16 + r)), 1'b0, (c == 6) && (r == 4), w);
        repeat (2) @(posedge clk);
        #1;
        chk("frame_pulse_count", COL_WIDTH'(pulse_seen), COL_WIDTH'(3));
        chk("frame_end_count", COL_WIDTH'(fe_seen), COL_WIDTH'(1));
        chk("frame_drained", COL_WIDTH'(sb.size()), '0);

        // Mid-column reset discards the partial column.
        do_reset();
        for (int r = 0; r < 3; r++) drive_beat(mk_row(16'(16'h0900 + r)), 1'b0, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", COL_WIDTH'(out_valid), '0);
        chk("midrst_pulse", COL_WIDTH'(pulse), '0);
        chk("midrst_feature", out_feature, '0);
        chk("midrst_in_ready", COL_WIDTH'(in_ready), COL_WIDTH'(1));
        rst   = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_col = 0;
        for (int r = 0; r < 5; r++) drive_beat(mk_row(16'(16'h0a00 + r)), 1'b0, 1'b0, w);
        chk("midrst_new_valid", COL_WIDTH'(out_valid), COL_WIDTH'(1));
        chk("midrst_new_pulse", COL_WIDTH'(pulse), COL_WIDTH'(1));
        chk("midrst_new_lane0", COL_WIDTH'(out_feature[79:0]),
            COL_WIDTH'({16'h0a04, 16'h0a03, 16'h0a02, 16'h0a01, 16'h0a00}));
        repeat (2) @(posedge clk);
        #1;
        chk("final_drained", COL_WIDTH'(sb.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
- Upstream stage of the max-pool array; assembles the window-column bus that the pool cores consume.
- Accepts a stream of 8-lane feature beats, one pooling row per beat.
- Packs MAXPOOL_SIZE consecutive beats into one column word of 5 rows × 8 lanes, with a valid/ready handshake.
- Drives the `pulse` that marks the first column of each pooling window.

Parameters:
- FEATURE_WIDTH, 16, bits per feature (signed two's complement).
- MAXPOOL_SIZE, 5, rows per column and columns per window.
- PE_ARRAY_SIZE, 8, parallel lanes (pool cores).
- PAD_VALUE, 16'h8000, fill for missing rows (most-negative value, neutral for max).

Ports:
- DSP_clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  feeder can accept a beat.
- in_data  in  FEATURE_WIDTH*PE_ARRAY_SIZE  one row: lane i at [i*FW +: FW].
- in_last  in  1  beat is the last row of the current column (early close).
- in_frame_end  in  1  beat ends the frame; next column restarts a window.
- out_valid  out  1  column word valid.
- out_ready  in  1  downstream accepts the column.
- out_feature  out  FW*MAXPOOL_SIZE*PE_ARRAY_SIZE  lane i row k at [(i*MAXPOOL_SIZE+k)*FW +: FW].
- pulse  out  1  qualified by out_valid; high when the column is window column 0.
- out_frame_end  out  1  qualified by out_valid; last column of the frame.

Behaviour:
- Reset (synchronous, `rst`=1 at a DSP_clk edge):
  - out_valid=0, pulse=0, out_frame_end=0, out_feature=0, in_ready=1.
  - row_cnt=0, col_cnt=0, gather empty.
  - Mid-operation reset discards the partial column and any held output word.
- Gather register:
  - An accepted beat (in_valid & in_ready) writes in_data into row slot row_cnt for every lane.
  - row_cnt increments on each accepted beat.
- Column close occurs on an accepted beat when row_cnt==MAXPOOL_SIZE-1, in_last=1, or in_frame_end=1.
  - Rows above the closing slot are filled with PAD_VALUE.
  - row_cnt returns to 0.
  - The closed column moves to the output register at the same edge if the output register is empty or being consumed; otherwise it waits in the gather register as pending.
- Output register:
  - out_valid rises the cycle after the closing beat (latency 1 from the 5th beat).
  - out_valid, out_feature, pulse and out_frame_end hold stable while out_valid & !out_ready.
  - Handshake completes on out_valid & out_ready.
- in_ready = !(gather pending).
  - Pending clears on the edge where the output register is consumed; the pending column loads at that edge.
  - Sustained throughput is one beat per cycle with out_ready=1.
- Window counter col_cnt:
  - pulse = (col_cnt==0) for the column in the output register.
  - col_cnt increments on output handshake and wraps from MAXPOOL_SIZE-1 to 0.
  - Forced to 0 after the handshake of a column with out_frame_end=1.
- Simultaneous events:
  - in_last and in_frame_end on the same beat: one close, frame_end flagged.
  - Closing beat plus output handshake in the same cycle: new column loads, no bubble.
- in_last on the row-0 beat: column is one real row plus 4 rows of PAD_VALUE.
- in_valid=0 never changes state; partial columns wait indefinitely.

Decomposition:
- Shared package: FEATURE_WIDTH, MAXPOOL_SIZE, PE_ARRAY_SIZE, PAD_VALUE, plus the lane/row bit-offset function for the column bus layout.
- One natural sub-module, pool_column_gather: row slot register, row_cnt, pad fill and close detection.
- The top level holds the output register, handshake logic and col_cnt.

Test Plan:
- Reset, then 5 beats with lane0 = 1,2,3,4,5 and out_ready=1 → one cycle later out_valid=1, pulse=1, lane0 rows = 1..5 at bits [0..79], in_ready stays 1.
- 25 back-to-back beats with out_ready=1 → 5 columns on consecutive 5-beat boundaries; pulse pattern 1,0,0,0,0; no in_ready drop.
- Beats 1,2 with in_last on the 2nd → column lane0 = 1,2,8000,8000,8000; row_cnt restarts at 0.
- out_ready=0 held for 10 cycles while 10 beats are offered:
  - in_ready falls after the 2nd column closes.
  - Output word stays stable.
  - Releasing out_ready delivers both columns in order, pulse then no pulse.
- Frame of 7 columns with in_frame_end on the last beat → pulse on columns 0 and 5, out_frame_end on column 6, next column pulse=1.
- rst asserted after 3 beats of a column → all outputs 0 next cycle; 5 fresh beats produce a column containing only the new data with pulse=1.
